// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the memory stage: decoder op/size selectors, fault causes
// and the access-controller state enum.
package mem_access_ctrl_pkg;

  localparam logic [1:0] MEM_OP_NOP   = 2'd0;
  localparam logic [1:0] MEM_OP_LOAD  = 2'd1;
  localparam logic [1:0] MEM_OP_STORE = 2'd2;

  localparam logic [2:0] MEM_SEL_NOP           = 3'd0;
  localparam logic [2:0] MEM_SEL_BYTE_SIGNED   = 3'd1;
  localparam logic [2:0] MEM_SEL_BYTE_UNSIGNED = 3'd2;
  localparam logic [2:0] MEM_SEL_HALF_SIGNED   = 3'd3;
  localparam logic [2:0] MEM_SEL_HALF_UNSIGNED = 3'd4;
  localparam logic [2:0] MEM_SEL_WORD          = 3'd5;

  localparam logic [1:0] CAUSE_NONE      = 2'b00;
  localparam logic [1:0] CAUSE_MIS_LOAD  = 2'b01;
  localparam logic [1:0] CAUSE_MIS_STORE = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RESP  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  // Unused selector codes (6, 7) behave like NOP.
  function automatic logic sel_is_nop(input logic [2:0] sel);
    return (sel == MEM_SEL_NOP) || (sel > MEM_SEL_WORD);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] sel, input logic [1:0] lo);
    case (sel)
      MEM_SEL_HALF_SIGNED, MEM_SEL_HALF_UNSIGNED: return lo[0];
      MEM_SEL_WORD:                               return lo != 2'b00;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: strobes and store replication for the request being issued,
// and extract/extension of read data for the request in flight.
module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [2:0]  st_sel_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [2:0]  ld_sel_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] rdata_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    case (st_sel_i)
      MEM_SEL_BYTE_SIGNED, MEM_SEL_BYTE_UNSIGNED: begin
        be_o    = 4'b0001 << st_off_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      MEM_SEL_HALF_SIGNED, MEM_SEL_HALF_UNSIGNED: begin
        be_o    = 4'b0011 << st_off_i;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ld_off_i)
      2'd0:    ld_byte = rdata_i[7:0];
      2'd1:    ld_byte = rdata_i[15:8];
      2'd2:    ld_byte = rdata_i[23:16];
      default: ld_byte = rdata_i[31:24];
    endcase
    ld_half = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (ld_sel_i)
      MEM_SEL_BYTE_SIGNED:   rdata_o = {{24{ld_byte[7]}}, ld_byte};
      MEM_SEL_BYTE_UNSIGNED: rdata_o = {24'd0, ld_byte};
      MEM_SEL_HALF_SIGNED:   rdata_o = {{16{ld_half[15]}}, ld_half};
      MEM_SEL_HALF_UNSIGNED: rdata_o = {16'd0, ld_half};
      default:               rdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store sequencer. Handshakes: start is taken only when busy=0;
// bus_req is held with stable bus outputs until a single-cycle bus_ack or timeout.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  mem_op,
  input  logic [2:0]  mem_sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  state_dbg
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic [2:0]    sel_q, sel_d;
  logic [1:0]    off_q, off_d;
  logic [31:0]   baddr_q, baddr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   bwdata_q, bwdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    cause_q, cause_d;

  logic [3:0]    be_nx;
  logic [31:0]   wrep_nx;
  logic [31:0]   ld_ext;
  logic          op_is_nop;

  mem_lane_align u_align (
    .st_sel_i (mem_sel),
    .st_off_i (addr[1:0]),
    .wdata_i  (wdata),
    .be_o     (be_nx),
    .wdata_o  (wrep_nx),
    .ld_sel_i (sel_q),
    .ld_off_i (off_q),
    .rdata_i  (bus_rdata),
    .rdata_o  (ld_ext)
  );

  assign op_is_nop = (mem_op != MEM_OP_LOAD) && (mem_op != MEM_OP_STORE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sel_d    = sel_q;
    off_d    = off_q;
    baddr_d  = baddr_q;
    be_d     = be_q;
    bwdata_d = bwdata_q;
    rdata_d  = rdata_q;
    cause_d  = cause_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rdata_d = '0;
          cause_d = CAUSE_NONE;
          if (op_is_nop || sel_is_nop(mem_sel)) begin
            state_d = ST_RESP;
          end else if (is_misaligned(mem_sel, addr[1:0])) begin
            state_d = ST_FAULT;
            cause_d = (mem_op == MEM_OP_LOAD) ? CAUSE_MIS_LOAD : CAUSE_MIS_STORE;
          end else begin
            state_d  = ST_REQ;
            cnt_d    = '0;
            op_d     = mem_op;
            sel_d    = mem_sel;
            off_d    = addr[1:0];
            baddr_d  = {addr[31:2], 2'b00};
            be_d     = be_nx;
            bwdata_d = wrep_nx;
          end
        end
      end
      ST_REQ: begin
        // An ack always wins, even in the last permitted cycle.
        if (bus_ack) begin
          state_d = ST_RESP;
          if (op_q == MEM_OP_LOAD) rdata_d = ld_ext;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = ST_FAULT;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= MEM_OP_NOP;
      sel_q    <= MEM_SEL_NOP;
      off_q    <= '0;
      baddr_q  <= '0;
      be_q     <= '0;
      bwdata_q <= '0;
      rdata_q  <= '0;
      cause_q  <= CAUSE_NONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sel_q    <= sel_d;
      off_q    <= off_d;
      baddr_q  <= baddr_d;
      be_q     <= be_d;
      bwdata_q <= bwdata_d;
      rdata_q  <= rdata_d;
      cause_q  <= cause_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_RESP) || (state_q == ST_FAULT);
  assign fault       = (state_q == ST_FAULT);
  assign fault_cause = cause_q;
  assign rdata       = rdata_q;
  assign bus_req     = (state_q == ST_REQ);
  assign bus_we      = (op_q == MEM_OP_STORE);
  assign bus_addr    = baddr_q;
  assign bus_be      = be_q;
  assign bus_wdata   = bwdata_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized and directed bench for mem_access_ctrl against an arithmetic model of
// load/store lane behaviour, latency and fault reporting.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mem_op = '0;
  logic [2:0]  mem_sel = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, fault, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [1:0]  fault_cause, state_dbg;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  int n_checks = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_op(mem_op), .mem_sel(mem_sel),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .fault(fault), .fault_cause(fault_cause), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // kind: 0 = no bus access, 1 = misaligned fault, 2 = bus access
  task automatic model(input logic [1:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input int ack_k,
                       output int kind, output logic [3:0] be, output logic [31:0] wrep,
                       output logic [31:0] rexp, output logic [1:0] cause, output int lat);
    int size;
    int off;
    logic sgn;
    longint v;
    size = (sel == MEM_SEL_BYTE_SIGNED || sel == MEM_SEL_BYTE_UNSIGNED) ? 1 :
           (sel == MEM_SEL_HALF_SIGNED || sel == MEM_SEL_HALF_UNSIGNED) ? 2 :
           (sel == MEM_SEL_WORD) ? 4 : 0;
    sgn  = (sel == MEM_SEL_BYTE_SIGNED || sel == MEM_SEL_HALF_SIGNED);
    off  = int'(a % 4);
    be = '0; wrep = '0; rexp = '0; cause = 2'd0; lat = 1;
    if (!(op == MEM_OP_LOAD || op == MEM_OP_STORE) || size == 0) begin
      kind = 0;
    end else if ((a % size) != 0) begin
      kind = 1;
      cause = (op == MEM_OP_LOAD) ? 2'd1 : 2'd2;
    end else begin
      kind = 2;
      be = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) wrep[8*i +: 8] = wd[8*(i % size) +: 8];
      if (op == MEM_OP_LOAD) begin
        v = (longint'(rd) >> (8 * off)) & ((64'd1 << (8 * size)) - 1);
        if (sgn && v >= longint'(64'd1 << (8 * size - 1))) v = v - longint'(64'd1 << (8 * size));
        rexp = v[31:0];
      end
      if (ack_k >= 1 && ack_k <= TO) lat = ack_k + 1;
      else begin lat = TO + 1; cause = 2'd3; end
    end
  endtask

  // Issue one request, act as the bus slave (ack in request cycle ack_k, 0 = never).
  task automatic run_txn(input string nm, input logic [1:0] op, input logic [2:0] sel,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int ack_k);
    int kind, lat, cyc, reqs, exp_reqs;
    logic [3:0] ebe;
    logic [31:0] ew, er, got_exp;
    logic [1:0] ec;
    logic seen;
    model(op, sel, a, wd, rd, ack_k, kind, ebe, ew, er, ec, lat);
    exp_q.push_back(er);
    @(negedge clk);
    start = 1'b1; mem_op = op; mem_sel = sel; addr = a; wdata = wd;
    @(negedge clk);
    start = 1'b0; addr = $urandom; wdata = $urandom;
    cyc = 1; reqs = 0; seen = 1'b0;
    while (!seen && cyc <= 20) begin
      bus_ack = 1'b0;
      bus_rdata = $urandom;
      if (bus_req) begin
        reqs++;
        n_checks++;
        if (bus_addr !== {a[31:2], 2'b00} || bus_be !== ebe || bus_we !== (op == MEM_OP_STORE)) begin
          n_err++;
          $display("FAIL %s bus_fields: addr=%h be=%b we=%b exp addr=%h be=%b we=%b",
                   nm, bus_addr, bus_be, bus_we, {a[31:2], 2'b00}, ebe, op == MEM_OP_STORE);
        end
        if (op == MEM_OP_STORE) begin
          n_checks++;
          if (bus_wdata !== ew) begin
            n_err++;
            $display("FAIL %s bus_wdata: got %h exp %h", nm, bus_wdata, ew);
          end
        end
        if (reqs == ack_k) begin bus_ack = 1'b1; bus_rdata = rd; end
      end
      if (done) seen = 1'b1;
      else begin @(negedge clk); cyc++; end
    end
    bus_ack = 1'b0;
    got_exp = exp_q.pop_front();
    exp_reqs = (kind == 2) ? lat - 1 : 0;
    n_checks++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s done_timeout: no done after %0d cycles, exp latency %0d", nm, cyc, lat);
    end else begin
      if (cyc != lat || reqs != exp_reqs) begin
        n_err++;
        $display("FAIL %s latency: got %0d cycles %0d req, exp %0d cycles %0d req", nm, cyc, reqs, lat, exp_reqs);
      end
      n_checks++;
      if (fault !== (ec != 2'd0) || fault_cause !== ec || busy !== 1'b1) begin
        n_err++;
        $display("FAIL %s fault: got fault=%b cause=%b busy=%b exp fault=%b cause=%b busy=1",
                 nm, fault, fault_cause, busy, ec != 2'd0, ec);
      end
      if (kind == 0 || (kind == 2 && op == MEM_OP_LOAD && ec == 2'd0)) begin
        n_checks++;
        if (rdata !== got_exp) begin
          n_err++;
          $display("FAIL %s rdata: got %h exp %h", nm, rdata, got_exp);
        end
      end
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s after_done: got done=%b busy=%b exp 0 0", nm, done, busy);
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({busy, done, fault, fault_cause, rdata, bus_req, bus_we, bus_addr, bus_be, bus_wdata, state_dbg} !== '0) begin
      n_err++;
      $display("FAIL reset_values: busy=%b done=%b fault=%b cause=%b rdata=%h req=%b we=%b baddr=%h be=%b bwd=%h st=%0d exp all 0",
               busy, done, fault, fault_cause, rdata, bus_req, bus_we, bus_addr, bus_be, bus_wdata, state_dbg);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sb();
    run_txn("sb", MEM_OP_STORE, MEM_SEL_BYTE_UNSIGNED, 32'h1002, 32'h0000_00AB, 32'h0, 1);
    run_txn("sh", MEM_OP_STORE, MEM_SEL_HALF_SIGNED, 32'h1006, 32'hCAFE_BEEF, 32'h0, 2);
  endtask

  task automatic test_lh_lhu();
    run_txn("lh", MEM_OP_LOAD, MEM_SEL_HALF_SIGNED, 32'h2002, 32'h0, 32'h8001_1234, 1);
    run_txn("lhu", MEM_OP_LOAD, MEM_SEL_HALF_UNSIGNED, 32'h2002, 32'h0, 32'h8001_1234, 3);
    run_txn("lb", MEM_OP_LOAD, MEM_SEL_BYTE_SIGNED, 32'h2003, 32'h0, 32'h80FF_0000, 1);
  endtask

  task automatic test_misaligned();
    run_txn("lw_mis", MEM_OP_LOAD, MEM_SEL_WORD, 32'h1001, 32'h0, 32'h0, 1);
    run_txn("sh_mis", MEM_OP_STORE, MEM_SEL_HALF_UNSIGNED, 32'h1003, 32'h1234, 32'h0, 1);
  endtask

  task automatic test_timeout();
    run_txn("lw_timeout", MEM_OP_LOAD, MEM_SEL_WORD, 32'h3000, 32'h0, 32'h0, 0);
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus_ack = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || bus_req !== 1'b0) begin
      n_err++;
      $display("FAIL stray_ack: got done=%b busy=%b req=%b exp 0 0 0", done, busy, bus_req);
    end
    run_txn("sw_after", MEM_OP_STORE, MEM_SEL_WORD, 32'h3004, 32'h1357_9BDF, 32'h0, 2);
    run_txn("lw_last_cycle", MEM_OP_LOAD, MEM_SEL_WORD, 32'h3008, 32'h0, 32'h0BAD_F00D, TO);
  endtask

  task automatic test_busy_ignore();
    int extra;
    @(negedge clk);
    start = 1'b1; mem_op = MEM_OP_LOAD; mem_sel = MEM_SEL_WORD; addr = 32'h400;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (bus_req !== 1'b1) begin n_err++; $display("FAIL busy_req1: got req=%b exp 1", bus_req); end
    @(negedge clk);
    start = 1'b1; mem_op = MEM_OP_STORE; mem_sel = MEM_SEL_BYTE_UNSIGNED; addr = 32'h401;
    bus_ack = 1'b1; bus_rdata = 32'h1122_3344;
    @(negedge clk);
    start = 1'b0; bus_ack = 1'b0;
    n_checks++;
    if (done !== 1'b1 || fault !== 1'b0 || rdata !== 32'h1122_3344) begin
      n_err++;
      $display("FAIL busy_done: got done=%b fault=%b rdata=%h exp 1 0 11223344", done, fault, rdata);
    end
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus_req || done) extra++;
    end
    n_checks++;
    if (extra != 0) begin n_err++; $display("FAIL busy_ignored: got %0d extra active cycles exp 0", extra); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; mem_op = MEM_OP_STORE; mem_sel = MEM_SEL_WORD; addr = 32'h500; wdata = 32'h5555_AAAA;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus_req !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: got req=%b busy=%b exp 0 0", bus_req, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (state_dbg !== 2'd0 || busy !== 1'b0 || bus_req !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: got state=%0d busy=%b req=%b exp 0 0 0", state_dbg, busy, bus_req);
    end
    run_txn("after_reset", MEM_OP_LOAD, MEM_SEL_BYTE_UNSIGNED, 32'h501, 32'h0, 32'h0000_9900, 1);
  endtask

  task automatic test_nop();
    run_txn("op_nop", MEM_OP_NOP, MEM_SEL_WORD, 32'h600, 32'h0, 32'h0, 1);
    run_txn("sel_nop", MEM_OP_LOAD, MEM_SEL_NOP, 32'h601, 32'h0, 32'h0, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_txn("rand", 2'($urandom_range(0, 2)), 3'($urandom_range(0, 5)), $urandom, $urandom,
              $urandom, int'($urandom_range(0, TO)));
    end
  endtask

  initial begin
    test_reset();
    test_sb();
    test_lh_lhu();
    test_misaligned();
    test_timeout();
    test_busy_ignore();
    test_reset_mid();
    test_nop();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
